// File: rtl/baud_pkg.sv
// Shared constants and helpers for the fractional-N baud tick generator.
// Increment calculation is done at elaboration time in 64-bit integer math.
package baud_pkg;

  localparam int unsigned DEF_BAUD0 = 9600;
  localparam int unsigned DEF_BAUD1 = 19200;
  localparam int unsigned DEF_BAUD2 = 57600;
  localparam int unsigned DEF_BAUD3 = 115200;

  localparam int RATE_SEL_W = 2;
  typedef logic [RATE_SEL_W-1:0] rate_sel_t;

  // Rounded increment: round(baud * oversample * 2^acc_width / clk_freq).
  function automatic logic [63:0] calc_inc(
    input logic [63:0] clk_freq,
    input logic [63:0] baud,
    input logic [63:0] oversample,
    input logic [63:0] acc_width
  );
    logic [63:0] num;
    num = (baud * oversample) << acc_width;
    return (num + (clk_freq >> 1)) / clk_freq;
  endfunction

endpackage

// File: rtl/baud_acc.sv
// Fractional phase accumulator: adds inc each enabled cycle and reports the
// carry out of the top bit, which marks one oversample period.
module baud_acc #(
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [ACC_WIDTH-1:0] inc,
  output logic                 carry
);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, inc};
  // A clear discards the add, so no carry can be reported in that cycle.
  assign carry = en & ~clr & w_sum[ACC_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= w_sum[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator top: rate selection, oversample divider and registered
// os/bit/mid strobes driven from the fractional accumulator carry.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned BAUD0      = DEF_BAUD0,
  parameter int unsigned BAUD1      = DEF_BAUD1,
  parameter int unsigned BAUD2      = DEF_BAUD2,
  parameter int unsigned BAUD3      = DEF_BAUD3
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  logic      restart,
  input  rate_sel_t rate_sel,
  output logic      os_tick,
  output logic      bit_tick,
  output logic      mid_tick,
  output rate_sel_t rate_q
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [63:0] INC_LIMIT = 64'd1 << ACC_WIDTH;

  localparam logic [63:0] INC_TAB [4] = '{
    calc_inc(64'(CLK_FREQ), 64'(BAUD0), 64'(OVERSAMPLE), 64'(ACC_WIDTH)),
    calc_inc(64'(CLK_FREQ), 64'(BAUD1), 64'(OVERSAMPLE), 64'(ACC_WIDTH)),
    calc_inc(64'(CLK_FREQ), 64'(BAUD2), 64'(OVERSAMPLE), 64'(ACC_WIDTH)),
    calc_inc(64'(CLK_FREQ), 64'(BAUD3), 64'(OVERSAMPLE), 64'(ACC_WIDTH))
  };

  for (genvar g = 0; g < 4; g++) begin : g_inc_check
    if (INC_TAB[g] < 64'd1 || INC_TAB[g] >= INC_LIMIT) begin : g_bad
      $error("baud_tick_gen: increment for rate %0d out of range", g);
    end
  end

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("baud_tick_gen: OVERSAMPLE must be even and at least 4");
  end

  rate_sel_t            r_rate_q;
  logic [CNT_W-1:0]     r_os_cnt;
  logic                 r_os_tick;
  logic                 r_bit_tick;
  logic                 r_mid_tick;
  logic [ACC_WIDTH-1:0] w_inc;
  logic                 w_rate_chg;
  logic                 w_clr;
  logic                 w_carry;

  assign w_inc      = INC_TAB[r_rate_q][ACC_WIDTH-1:0];
  // A rate change is treated as an implicit restart so phase starts clean.
  assign w_rate_chg = (rate_sel != r_rate_q);
  assign w_clr      = w_rate_chg | restart;

  baud_acc #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .en   (en),
    .inc  (w_inc),
    .carry(w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rate_q   <= '0;
      r_os_cnt   <= '0;
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
      r_mid_tick <= 1'b0;
    end else begin
      if (w_rate_chg) begin
        r_rate_q <= rate_sel;
      end
      if (w_clr) begin
        r_os_cnt   <= '0;
        r_os_tick  <= 1'b0;
        r_bit_tick <= 1'b0;
        r_mid_tick <= 1'b0;
      end else if (!en) begin
        r_os_tick  <= 1'b0;
        r_bit_tick <= 1'b0;
        r_mid_tick <= 1'b0;
      end else begin
        r_os_tick  <= w_carry;
        r_bit_tick <= w_carry & (r_os_cnt == CNT_LAST);
        r_mid_tick <= w_carry & (r_os_cnt == CNT_MID);
        if (w_carry) begin
          r_os_cnt <= (r_os_cnt == CNT_LAST) ? '0 : r_os_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign os_tick  = r_os_tick;
  assign bit_tick = r_bit_tick;
  assign mid_tick = r_mid_tick;
  assign rate_q   = r_rate_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: table of tick-count vectors from a
// clean start plus directed restart, rate-change, enable-gap and reset cases.
module tb_baud_tick_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       restart;
  logic [1:0] rate_sel;
  logic       os_tick;
  logic       bit_tick;
  logic       mid_tick;
  logic [1:0] rate_q;

  int compared;
  int mismatched;

  typedef struct {
    logic [1:0] rate;
    int         cycles;
    int         gapLo;
    int         gapHi;
    int         expOs;
    int         expBit;
    int         expMid;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  baud_tick_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .restart (restart),
    .rate_sel(rate_sel),
    .os_tick (os_tick),
    .bit_tick(bit_tick),
    .mid_tick(mid_tick),
    .rate_q  (rate_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reset, select the rate, let one edge absorb the rate change, then enable.
  task automatic applyStimulus(input logic [1:0] rate);
    rst_n    = 1'b0;
    en       = 1'b0;
    restart  = 1'b0;
    rate_sel = rate;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b1;
  endtask

  task automatic runEdges(input int n, input int gapLo, input int gapHi,
                          output int nOs, output int nBit, output int nMid, output int nBad);
    int since;
    since = -1;
    nOs = 0; nBit = 0; nMid = 0; nBad = 0;
    for (int e = 0; e < n; e++) begin
      @(posedge clk);
      #1;
      if (since >= 0) since++;
      if (os_tick) begin
        nOs++;
        if (since >= 0 && gapLo > 0 && (since < gapLo || since > gapHi)) nBad++;
        since = 0;
      end
      if ((bit_tick || mid_tick) && !os_tick) nBad++;
      if (bit_tick && mid_tick) nBad++;
      if (bit_tick) nBit++;
      if (mid_tick) nMid++;
    end
  endtask

  task automatic scanAfterClear(input int limit, output int firstEdge,
                                output int midIdx, output int bitIdx);
    int nOs;
    nOs = 0; firstEdge = -1; midIdx = -1; bitIdx = -1;
    for (int e = 1; e <= limit && bitIdx < 0; e++) begin
      @(posedge clk);
      #1;
      if (os_tick) begin
        nOs++;
        if (firstEdge < 0) firstEdge = e;
      end
      if (mid_tick && midIdx < 0) midIdx = nOs;
      if (bit_tick) bitIdx = nOs;
    end
  endtask

  task automatic waitOsTicks(input int target, input int limit, output int seen);
    seen = 0;
    for (int e = 0; e < limit && seen < target; e++) begin
      @(posedge clk);
      #1;
      if (os_tick) seen++;
    end
  endtask

  initial begin
    int nOs, nBit, nMid, nBad;
    int a1, b1, m1, x1, a2, b2, m2, x2, a3, b3, m3, x3;
    int firstEdge, midIdx, bitIdx, seen;

    compared   = 0;
    mismatched = 0;

    vecs[0]  = '{2'd3, 13,    13,  14,  0,    0,   0};
    vecs[1]  = '{2'd3, 14,    13,  14,  1,    0,   0};
    vecs[2]  = '{2'd3, 108,   13,  14,  7,    0,   0};
    vecs[3]  = '{2'd3, 109,   13,  14,  8,    0,   1};
    vecs[4]  = '{2'd3, 217,   13,  14,  15,   0,   1};
    vecs[5]  = '{2'd3, 218,   13,  14,  16,   1,   1};
    vecs[6]  = '{2'd3, 2000,  13,  14,  147,  9,   9};
    vecs[7]  = '{2'd0, 10000, 162, 163, 61,   3,   4};
    vecs[8]  = '{2'd1, 10000, 81,  82,  122,  7,   8};
    vecs[9]  = '{2'd2, 10000, 27,  28,  368,  23,  23};
    vecs[10] = '{2'd3, 20000, 13,  14,  1474, 92,  92};

    // Reset state while held in reset with a nonzero rate request.
    rst_n = 1'b0; en = 1'b1; restart = 1'b0; rate_sel = 2'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_os",   int'(os_tick),  0);
    checkOutput("reset_bit",  int'(bit_tick), 0);
    checkOutput("reset_mid",  int'(mid_tick), 0);
    checkOutput("reset_rate", int'(rate_q),   0);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].rate);
      runEdges(vecs[i].cycles, vecs[i].gapLo, vecs[i].gapHi, nOs, nBit, nMid, nBad);
      checkOutput($sformatf("v%0d_os", i),   nOs,  vecs[i].expOs);
      checkOutput($sformatf("v%0d_bit", i),  nBit, vecs[i].expBit);
      checkOutput($sformatf("v%0d_mid", i),  nMid, vecs[i].expMid);
      checkOutput($sformatf("v%0d_bad", i),  nBad, 0);
      checkOutput($sformatf("v%0d_rate", i), int'(rate_q), int'(vecs[i].rate));
    end

    // First tick after start takes 14 adds; mid on 8th, bit on 16th os_tick.
    applyStimulus(2'd3);
    scanAfterClear(400, firstEdge, midIdx, bitIdx);
    checkOutput("start_first", firstEdge, 14);
    checkOutput("start_mid",   midIdx,    8);
    checkOutput("start_bit",   bitIdx,    16);

    // Restart five cycles after the 9th os_tick of a fresh bit.
    applyStimulus(2'd3);
    waitOsTicks(9, 400, seen);
    checkOutput("rst9_seen", seen, 9);
    runEdges(4, 0, 0, nOs, nBit, nMid, nBad);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    checkOutput("restart_os", int'(os_tick), 0);
    scanAfterClear(400, firstEdge, midIdx, bitIdx);
    checkOutput("restart_first", firstEdge, 14);
    checkOutput("restart_mid",   midIdx,    8);
    checkOutput("restart_bit",   bitIdx,    16);

    // Rate change 3 -> 0 mid-bit.
    runEdges(50, 0, 0, nOs, nBit, nMid, nBad);
    rate_sel = 2'd0;
    @(posedge clk);
    #1;
    checkOutput("rchg_ticks", int'(os_tick) + int'(bit_tick) + int'(mid_tick), 0);
    checkOutput("rchg_rate",  int'(rate_q), 0);
    scanAfterClear(4000, firstEdge, midIdx, bitIdx);
    checkOutput("rchg_first", firstEdge, 163);
    checkOutput("rchg_mid",   midIdx,    8);
    checkOutput("rchg_bit",   bitIdx,    16);

    // Rate change and restart together: a single clear, new rate taken.
    runEdges(300, 0, 0, nOs, nBit, nMid, nBad);
    rate_sel = 2'd2;
    restart  = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    checkOutput("both_ticks", int'(os_tick) + int'(bit_tick) + int'(mid_tick), 0);
    checkOutput("both_rate",  int'(rate_q), 2);
    scanAfterClear(1000, firstEdge, midIdx, bitIdx);
    checkOutput("both_first", firstEdge, 28);
    checkOutput("both_bit",   bitIdx,    16);

    // Restart held high keeps everything quiet; restart beats en=0.
    rate_sel = 2'd3;
    restart  = 1'b1;
    runEdges(40, 0, 0, nOs, nBit, nMid, nBad);
    checkOutput("hold_os", nOs, 0);
    restart = 1'b0;
    runEdges(120, 0, 0, nOs, nBit, nMid, nBad);
    en      = 1'b0;
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    en      = 1'b1;
    scanAfterClear(400, firstEdge, midIdx, bitIdx);
    checkOutput("rsten_first", firstEdge, 14);
    checkOutput("rsten_bit",   bitIdx,    16);

    // Enable gap: phase is preserved, totals match the gapless 218-add run.
    applyStimulus(2'd3);
    runEdges(100, 0, 0, a1, b1, m1, x1);
    en = 1'b0;
    runEdges(50, 0, 0, a2, b2, m2, x2);
    en = 1'b1;
    runEdges(118, 0, 0, a3, b3, m3, x3);
    checkOutput("gap_low_ticks", a2 + b2 + m2, 0);
    checkOutput("gap_os",  a1 + a3, 16);
    checkOutput("gap_bit", b1 + b3, 1);
    checkOutput("gap_mid", m1 + m3, 1);
    checkOutput("gap_bad", x1 + x2 + x3, 0);

    // Asynchronous reset while os_tick is high, checked before the next edge.
    applyStimulus(2'd3);
    seen = 0;
    for (int e = 0; e < 100 && seen == 0; e++) begin
      @(posedge clk);
      #1;
      if (os_tick) seen = 1;
    end
    checkOutput("arst_pre_os", seen, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_os",   int'(os_tick),  0);
    checkOutput("arst_bit",  int'(bit_tick), 0);
    checkOutput("arst_mid",  int'(mid_tick), 0);
    checkOutput("arst_rate", int'(rate_q),   0);
    rst_n = 1'b1;
    #1;
    checkOutput("arst_rate_rel", int'(rate_q), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised fractional-N baud tick generator for the UART path. Produces an oversampling tick (Baud × OVERSAMPLE) for the receiver, plus bit-rate and mid-bit strobes for transmitter and sampler. Four baud rates are selectable at run time. Phase can be re-aligned on demand, for example on start-bit detection. Sits between the FPGA clock and the UART TX/RX blocks.

## Interface
- CLK_FREQ, 25000000, input clock frequency in Hz
- ACC_WIDTH, 16, fractional accumulator width in bits
- OVERSAMPLE, 16, os_tick per bit period; even, ≥4
- BAUD0, 9600, rate for rate_sel=0
- BAUD1, 19200, rate for rate_sel=1
- BAUD2, 57600, rate for rate_sel=2
- BAUD3, 115200, rate for rate_sel=3
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  count enable; low freezes all state
- restart  in  1  synchronous phase realign, single-cycle pulse
- rate_sel  in  2  baud rate select
- os_tick  out  1  oversample tick, one-cycle pulse
- bit_tick  out  1  one-cycle pulse per bit period, coincident with an os_tick
- mid_tick  out  1  one-cycle pulse at mid-bit, coincident with an os_tick
- rate_q  out  2  currently active rate selection

## Operation
- INCk = round(BAUDk·OVERSAMPLE·2^ACC_WIDTH / CLK_FREQ), evaluated at elaboration in 64-bit integer math.
- Elaboration fails unless 1 ≤ INCk < 2^ACC_WIDTH.
- State:
  - acc[ACC_WIDTH-1:0]
  - os_cnt[$clog2(OVERSAMPLE)-1:0]
  - rate_q[1:0]
  - registered outputs
- Each cycle, the first matching case applies, in this priority order:
  1. rate_sel ≠ rate_q: rate_q ← rate_sel; acc ← 0; os_cnt ← 0; all ticks ← 0. This is an implicit restart.
  2. restart=1: acc ← 0; os_cnt ← 0; all ticks ← 0.
  3. en=0: acc and os_cnt hold; all ticks ← 0.
  4. Otherwise:
     - sum = {1'b0,acc} + INC[rate_q], width ACC_WIDTH+1; acc ← sum[ACC_WIDTH-1:0]; os_tick ← sum[ACC_WIDTH].
     - On carry: os_cnt ← (os_cnt==OVERSAMPLE-1) ? 0 : os_cnt+1.
     - bit_tick ← carry & (os_cnt==OVERSAMPLE-1).
     - mid_tick ← carry & (os_cnt==OVERSAMPLE/2-1).
- No carry is ever lost. Long-term os_tick rate is exactly INC·CLK_FREQ/2^ACC_WIDTH.
- Between consecutive os_ticks the gap is floor or ceil of 2^ACC_WIDTH/INC cycles, with no other spacing.

## Timing
- Reset values: acc=0, os_cnt=0, rate_q=0, os_tick=bit_tick=mid_tick=0.
- All outputs are registered; there are no combinational input-to-output paths.
- Latency: an overflowing add on edge n gives os_tick high for the cycle after edge n.
- restart or a rate change at edge n:
  - Ticks are low after edge n.
  - The next add occurs at edge n+1.
  - The first os_tick after realign follows exactly ceil(2^ACC_WIDTH/INC) enabled adds.
- restart held high keeps the block in the cleared state with no ticks.
- restart and en=0 together: restart wins.
- Rate change and restart together: one clear only; rate_q takes the new value.
- bit_tick and mid_tick never assert without os_tick in the same cycle. They never coincide, since OVERSAMPLE ≥ 4.
- en deasserting mid-bit does not discard phase. Resuming continues from the held acc and os_cnt.
- rst_n assertion mid-operation clears everything immediately (asynchronous). Deassertion is expected to be synchronised externally.

## Structure
- Package baud_pkg holds:
  - function calc_inc(clk_freq, baud, oversample, acc_width), returning the rounded increment;
  - default baud constants 9600/19200/57600/115200;
  - localparam type for the rate-select width.
- Sub-module baud_acc (ACC_WIDTH; ports clk, rst_n, clr, en, inc, carry) implements the fractional accumulator.
- The top level holds the increment mux, rate_q tracking, os_cnt divider and output registers.

## Test plan
All scenarios use the defaults, CLK_FREQ=25 MHz and ACC_WIDTH=16; rate 3 gives INC3=4832.
- Reset release, en=1, rate_sel=3: first os_tick is high after edge 14 (14·4832=67648 ≥ 65536). Intervals alternate 13/14 cycles; first bit_tick is on the 16th os_tick; first mid_tick is on the 8th.
- 100000 enabled cycles at rate 3: os_tick count = 7373 ±1 and bit_tick count = 460 ±1.
- Switch rate_sel 3→0 mid-bit (INC0=403): ticks clear for one cycle and rate_q=0 next cycle. The first os_tick comes 163 adds later, and the average interval converges to 162.6 cycles.
- restart pulsed 5 cycles after an os_tick with os_cnt=9: os_cnt=0, no tick that cycle, next os_tick after 14 adds, bit_tick after 16 os_ticks.
- en low for 50 cycles mid-bit: zero ticks while low. acc and os_cnt are unchanged on resume, and total tick count equals that of the same run with the gap removed.
- rst_n asserted asynchronously between edges: all outputs go to 0 without waiting for a clock edge. rate_q=0 after release.
